config_injector: RTL and testbench

Source end of the mesh configuration protocol. Accepts per-PE configuration entries (target row/column, port sampler, out designator, instruction, 32-bit immediate) over a valid/ready handshake. Builds each 48-bit config packet with its hop-by-hop routing sequence and injects it into the entry switch at mesh position (0,0). It holds the fabric-wide `load` high for the whole configuration phase, then signals completion.

---
 rtl/accel_cfg_pkg.sv | 27 ++
 rtl/cfg_route_encoder.sv | 24 ++
 rtl/config_injector.sv | 149 ++++++++++++++
 tb/tb_config_injector.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_cfg_pkg.sv
// Shared types and constants for the mesh configuration protocol.
package accel_cfg_pkg;

  localparam int unsigned ROUTE_W = 8;
  localparam logic [ROUTE_W-1:0] ROUTE_ARRIVED = 8'h80;
  localparam logic [47:0] CFG_IDLE = 48'h0;

  // Route bit meaning at each switch: 1 = go east, 0 = go south.
  localparam logic EAST  = 1'b1;
  localparam logic SOUTH = 1'b0;

  typedef struct packed {
    logic [ROUTE_W-1:0] route;
    logic [1:0]         port_sampler;
    logic [1:0]         out_designator;
    logic [3:0]         instruction;
    logic [31:0]        data;
  } cfg_packet_t;

  typedef enum logic [1:0] {
    INJ_IDLE,
    INJ_SEND,
    INJ_FLIGHT,
    INJ_DONE
  } inj_state_t;

endpackage

// File: rtl/cfg_route_encoder.sv
// Combinational route builder: col east hops, row south hops, sentinel, zero fill.
module cfg_route_encoder
  import accel_cfg_pkg::*;
(
  input  logic [1:0]         row,
  input  logic [1:0]         col,
  output logic [ROUTE_W-1:0] route,
  output logic [2:0]         hops
);

  // Sentinel lands just after the last hop; east bits are overlaid first.
  always_comb begin
    hops  = {1'b0, col} + {1'b0, row};
    route = ROUTE_ARRIVED >> hops;
    for (int unsigned i = 0; i < ROUTE_W; i++) begin
      if (i < 32'(col)) begin
        route[ROUTE_W-1-i] = EAST;
      end else if (i < 32'(hops)) begin
        route[ROUTE_W-1-i] = SOUTH;
      end
    end
  end

endmodule

// File: rtl/config_injector.sv
// Source end of the mesh configuration protocol: builds and injects config packets at (0,0).
module config_injector
  import accel_cfg_pkg::*;
#(
  parameter int unsigned ROWS        = 4,
  parameter int unsigned COLS        = 4,
  parameter int unsigned DRAIN_SLACK = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_row,
  input  logic [1:0]  cfg_col,
  input  logic [1:0]  cfg_port_sampler,
  input  logic [1:0]  cfg_out_designator,
  input  logic [3:0]  cfg_instruction,
  input  logic [31:0] cfg_data,
  input  logic        cfg_last,
  output logic [47:0] out_config,
  output logic        load,
  output logic        done,
  output logic        cfg_err,
  output logic [4:0]  pkt_count
);

  inj_state_t  state_q, state_n;
  cfg_packet_t pkt_q, pkt_n;
  logic        ready_q, ready_n;
  logic        load_q, load_n;
  logic        done_q, done_n;
  logic        err_q, err_n;
  logic        last_q, last_n;
  logic [4:0]  count_q, count_n;
  logic [7:0]  flight_q, flight_n;

  logic [ROUTE_W-1:0] route;
  logic [2:0]         hops;
  logic               accept;
  logic               in_range;

  cfg_route_encoder u_route (
    .row   (cfg_row),
    .col   (cfg_col),
    .route (route),
    .hops  (hops)
  );

  assign accept   = cfg_valid & ready_q;
  assign in_range = (32'(cfg_row) < ROWS) && (32'(cfg_col) < COLS);

  assign cfg_ready  = ready_q;
  assign out_config = pkt_q;
  assign load       = load_q;
  assign done       = done_q;
  assign cfg_err    = err_q;
  assign pkt_count  = count_q;

  // Next-state and next-output logic; every output is the registered copy of these.
  always_comb begin
    state_n  = state_q;
    pkt_n    = CFG_IDLE;
    ready_n  = ready_q;
    load_n   = load_q;
    done_n   = done_q;
    err_n    = err_q;
    last_n   = last_q;
    count_n  = count_q;
    flight_n = flight_q;
    case (state_q)
      INJ_IDLE, INJ_DONE: begin
        if (accept) begin
          if (in_range) begin
            // Packet is registered at the accept edge so it is on the wire during SEND;
            // the flight window is captured here too and only starts counting in FLIGHT.
            pkt_n.route          = route;
            pkt_n.port_sampler   = cfg_port_sampler;
            pkt_n.out_designator = cfg_out_designator;
            pkt_n.instruction    = cfg_instruction;
            pkt_n.data           = cfg_data;
            last_n   = cfg_last;
            flight_n = 8'(2 * (32'(hops) + 1) + DRAIN_SLACK);
            ready_n  = 1'b0;
            load_n   = 1'b1;
            done_n   = 1'b0;
            state_n  = INJ_SEND;
          end else begin
            err_n = 1'b1;
            if (cfg_last) begin
              state_n = INJ_DONE;
              done_n  = 1'b1;
              load_n  = 1'b0;
            end else begin
              state_n = INJ_IDLE;
              done_n  = 1'b0;
            end
          end
        end
      end
      INJ_SEND: begin
        if (count_q != '1) begin
          count_n = count_q + 5'd1;
        end
        state_n = INJ_FLIGHT;
      end
      INJ_FLIGHT: begin
        if (flight_q <= 8'd1) begin
          ready_n = 1'b1;
          if (last_q) begin
            state_n = INJ_DONE;
            done_n  = 1'b1;
            load_n  = 1'b0;
          end else begin
            state_n = INJ_IDLE;
          end
        end else begin
          flight_n = flight_q - 8'd1;
        end
      end
      default: state_n = INJ_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= INJ_IDLE;
      pkt_q    <= CFG_IDLE;
      ready_q  <= 1'b1;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      last_q   <= 1'b0;
      count_q  <= '0;
      flight_q <= '0;
    end else begin
      state_q  <= state_n;
      pkt_q    <= pkt_n;
      ready_q  <= ready_n;
      load_q   <= load_n;
      done_q   <= done_n;
      err_q    <= err_n;
      last_q   <= last_n;
      count_q  <= count_n;
      flight_q <= flight_n;
    end
  end

endmodule

// File: tb/tb_config_injector.sv
// Scoreboard bench for config_injector: driver pushes expected packets, monitor pops on each send.
module tb_config_injector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cfg_valid, cfg_last, cfg_ready, load, done, cfg_err;
  logic [1:0]  cfg_row, cfg_col, cfg_ps, cfg_od;
  logic [3:0]  cfg_instr;
  logic [31:0] cfg_data;
  logic [47:0] out_config;
  logic [4:0]  pkt_count;

  logic        reset2, cfg_valid2, cfg_last2, cfg_ready2, load2, done2, cfg_err2;
  logic [1:0]  cfg_row2, cfg_col2;
  logic [31:0] cfg_data2;
  logic [47:0] out_config2;
  logic [4:0]  pkt_count2;

  config_injector #(.ROWS(4), .COLS(4), .DRAIN_SLACK(2)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_port_sampler(cfg_ps),
    .cfg_out_designator(cfg_od), .cfg_instruction(cfg_instr), .cfg_data(cfg_data),
    .cfg_last(cfg_last), .out_config(out_config), .load(load), .done(done),
    .cfg_err(cfg_err), .pkt_count(pkt_count)
  );

  config_injector #(.ROWS(2), .COLS(4), .DRAIN_SLACK(2)) dut2 (
    .clk(clk), .reset(reset2), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
    .cfg_row(cfg_row2), .cfg_col(cfg_col2), .cfg_port_sampler(2'd0),
    .cfg_out_designator(2'd0), .cfg_instruction(4'd0), .cfg_data(cfg_data2),
    .cfg_last(cfg_last2), .out_config(out_config2), .load(load2), .done(done2),
    .cfg_err(cfg_err2), .pkt_count(pkt_count2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  typedef struct {
    logic [47:0] pkt;
    int          w;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   sends = 0;
  int   prev_send = 0;
  int   prev_w = 0;
  bit   gap_valid = 1'b0;

  // Monitor: every non-idle word on out_config must match the oldest expected packet.
  always @(negedge clk) begin
    if (out_config !== 48'h0) begin
      sends++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_packet: got %0h expected none", out_config);
      end else begin
        mon_e = sbq.pop_front();
        check("packet", out_config, mon_e.pkt);
        check("send_latency", 48'(cyc), 48'(mon_e.acc));
        if (gap_valid) begin
          checks++;
          if (cyc - prev_send < prev_w + 1) begin
            errors++;
            $display("FAIL send_gap: got %0d cycles expected at least %0d", cyc - prev_send, prev_w + 1);
          end
        end
        prev_send = cyc;
        prev_w    = mon_e.w;
        gap_valid = 1'b1;
      end
    end
  end

  // Independent route formula: col leading ones, sentinel after row+col hops.
  function automatic logic [47:0] exp_pkt(input logic [1:0] r, input logic [1:0] c,
                                           input logic [1:0] ps, input logic [1:0] od,
                                           input logic [3:0] ins, input logic [31:0] d);
    int ri, ci, rt;
    ri = int'(r);
    ci = int'(c);
    rt = ((32'h80 >> (ri + ci)) | (32'hFF << (8 - ci))) & 32'hFF;
    return {rt[7:0], ps, od, ins, d};
  endfunction

  task automatic drive(input logic [1:0] r, input logic [1:0] c, input logic [1:0] ps,
                       input logic [1:0] od, input logic [3:0] ins, input logic [31:0] d,
                       input logic lst, input bit keep, input logic [47:0] expect_pkt);
    int unsigned n;
    exp_t e;
    @(negedge clk);
    cfg_row = r; cfg_col = c; cfg_ps = ps; cfg_od = od;
    cfg_instr = ins; cfg_data = d; cfg_last = lst; cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) begin
      fail_now("accept_wait");
      cfg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.pkt = expect_pkt;
    e.w   = 2 * (int'(r) + int'(c) + 1) + 2;
    e.acc = cyc;
    sbq.push_back(e);
    if (!keep) cfg_valid = 1'b0;
  endtask

  // Counts cycles with cfg_ready low (n) and, among them, cycles with idle out_config (z).
  task automatic count_low(output int n, output int z);
    n = 0;
    z = 0;
    @(negedge clk);
    while (!cfg_ready && n < 100) begin
      n++;
      if (out_config === 48'h0) z++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, z, sends0;
    reset = 1'b1; reset2 = 1'b1;
    cfg_valid = 1'b0; cfg_row = '0; cfg_col = '0; cfg_ps = '0; cfg_od = '0;
    cfg_instr = '0; cfg_data = '0; cfg_last = 1'b0;
    cfg_valid2 = 1'b0; cfg_row2 = '0; cfg_col2 = '0; cfg_data2 = '0; cfg_last2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_config", out_config, 48'h0);
    check("rst_load", 48'(load), 48'h0);
    check("rst_done", 48'(done), 48'h0);
    check("rst_err", 48'(cfg_err), 48'h0);
    check("rst_pkt_count", 48'(pkt_count), 48'h0);
    check("rst_ready", 48'(cfg_ready), 48'h1);
    @(negedge clk);
    reset = 1'b0; reset2 = 1'b0;

    // Origin target: arrived route, W = 4.
    drive(2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 32'h0, 1'b0, 1'b0, 48'h800000000000);
    check("t1_load", 48'(load), 48'h1);
    count_low(n, z);
    check("t1_ready_low", 48'(n), 48'd5);
    check("t1_idle_cycles", 48'(z), 48'd4);

    // Row 2 col 1: W = 10.
    drive(2'd2, 2'd1, 2'd1, 2'd2, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0, 48'h9065DEADBEEF);
    count_low(n, z);
    check("t2_ready_low", 48'(n), 48'd11);
    check("t2_idle_cycles", 48'(z), 48'd10);

    // Far corner with last: W = 16, then DONE.
    drive(2'd3, 2'd3, 2'd2, 2'd1, 4'hA, 32'h12345678, 1'b1, 1'b0, 48'hE29A12345678);
    count_low(n, z);
    check("t3_ready_low", 48'(n), 48'd17);
    check("t3_idle_cycles", 48'(z), 48'd16);
    check("t3_done", 48'(done), 48'h1);
    check("t3_load", 48'(load), 48'h0);
    check("t3_pkt_count", 48'(pkt_count), 48'd3);
    check("t3_ready", 48'(cfg_ready), 48'h1);

    // Accept from DONE restarts the flow.
    drive(2'd0, 2'd1, 2'd0, 2'd0, 4'd0, 32'h0, 1'b0, 1'b0, 48'hC00000000000);
    check("t4_done_clear", 48'(done), 48'h0);
    check("t4_load", 48'(load), 48'h1);
    count_low(n, z);
    check("t4_ready_low", 48'(n), 48'd7);

    // Reset in the middle of FLIGHT.
    drive(2'd1, 2'd2, 2'd0, 2'd0, 4'd0, 32'h1, 1'b0, 1'b0, 48'hD00000000001);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    gap_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t5_load", 48'(load), 48'h0);
    check("t5_out_config", out_config, 48'h0);
    check("t5_pkt_count", 48'(pkt_count), 48'h0);
    check("t5_ready", 48'(cfg_ready), 48'h1);
    @(negedge clk);
    reset = 1'b0;

    // 17 entries with cfg_valid held high.
    sends0 = sends;
    for (int i = 0; i < 17; i++) begin
      logic [1:0]  r, c, ps, od;
      logic [3:0]  ins;
      logic [31:0] d;
      r   = 2'(i % 4);
      c   = 2'((i / 4) % 4);
      ps  = 2'(i % 4);
      od  = 2'((i + 1) % 4);
      ins = 4'(i % 16);
      d   = 32'(i) * 32'h01010101;
      drive(r, c, ps, od, ins, d, (i == 16), (i != 16), exp_pkt(r, c, ps, od, ins, d));
    end
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail_now("t6_done_wait");
    @(negedge clk);
    check("t6_done", 48'(done), 48'h1);
    check("t6_load", 48'(load), 48'h0);
    check("t6_pkt_count", 48'(pkt_count), 48'd17);
    check("t6_sends", 48'(sends - sends0), 48'd17);

    // ROWS = 2 instance: out-of-range row is dropped and flagged.
    @(negedge clk);
    cfg_row2 = 2'd3; cfg_col2 = 2'd0; cfg_data2 = 32'h0; cfg_last2 = 1'b0; cfg_valid2 = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid2 = 1'b0;
    check("t7_err", 48'(cfg_err2), 48'h1);
    check("t7_out_config", out_config2, 48'h0);
    check("t7_ready", 48'(cfg_ready2), 48'h1);
    check("t7_load", 48'(load2), 48'h0);
    @(posedge clk);
    #1;
    check("t7_no_send", out_config2, 48'h0);
    check("t7_pkt_count", 48'(pkt_count2), 48'h0);
    @(negedge clk);
    cfg_row2 = 2'd1; cfg_col2 = 2'd1; cfg_data2 = 32'h55; cfg_valid2 = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid2 = 1'b0;
    check("t7_packet", out_config2, 48'hA00000000055);
    check("t7_load_up", 48'(load2), 48'h1);
    @(posedge clk);
    #1;
    check("t7_pkt_count_after", 48'(pkt_count2), 48'd1);
    check("t7_err_sticky", 48'(cfg_err2), 48'h1);

    repeat (2) @(negedge clk);
    check("sb_empty", 48'(sbq.size()), 48'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
